load_align_unit: RTL
====================

# load_align_unit

Parametrised load formatter between the data-memory port and the register-file write-back path. It generalises the fixed word/half/byte truncation to:
- any power-of-two bus width;
- byte-offset alignment;
- signed or unsigned extension;
- optional two-beat assembly of loads that cross a word boundary.

Requests and responses use valid/ready handshakes. A small FSM drives the memory read port and holds the formatted result until write-back accepts it.

## Interface
Parameters:
- DATA_W, 32: bus and result width; 32 or 64. NB = DATA_W/8 bytes; OFF_W = log2(NB).
- MISALIGN_EN, 1: 1 = misaligned loads are assembled (two beats if crossing); 0 = misaligned loads return an error.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_off  in  OFF_W  byte offset of the first byte within the word.
- req_size  in  2  0 = full word (NB bytes), 1 = half (2 bytes), 2 = byte (1 byte), 3 = reserved.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_req  out  1  read request to memory, held until mem_rvalid.
- mem_next  out  1  0 = read addressed word, 1 = read following word (address + NB).
- mem_rvalid  in  1  mem_rdata valid this cycle; completes the current read.
- mem_rdata  in  DATA_W  memory word, little-endian (byte 0 = bits [7:0]).
- resp_valid  out  1  formatted result available.
- resp_ready  in  1  write-back accepts the result.
- resp_data  out  DATA_W  formatted, extended load result.
- resp_err  out  1  the response is an error (reserved size, or misaligned with MISALIGN_EN=0).

## Operation
- Access length: n = NB for size 0, 2 for size 1, 1 for size 2.
- Misaligned: req_off mod n ≠ 0. Crossing: req_off + n > NB.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid, latch off, size and signed, then:
  - error condition (size 3, or misaligned with MISALIGN_EN=0) → RESP with resp_err=1, resp_data=0, no memory access;
  - otherwise → BEAT0.
- BEAT0: mem_req=1, mem_next=0. On mem_rvalid, capture the word into buffer low, then:
  - crossing → BEAT1;
  - not crossing → RESP.
- BEAT1: mem_req=1, mem_next=1. On mem_rvalid, capture the word into buffer high → RESP.
- Formatting (registered on entry to RESP):
  - form {high, low} (2·DATA_W) and shift right by off·8;
  - take the low n·8 bits;
  - extend to DATA_W using bit n·8−1 if signed, else zeros;
  - size 0 ignores req_signed.
- RESP: resp_valid=1; resp_data and resp_err are held stable. On resp_ready → IDLE.
- mem_rvalid is ignored in IDLE and RESP (stale returns after reset are dropped).
- Only one request is in flight; no request is accepted while the block is busy.
- Reset values: state IDLE, req_ready=1, mem_req=0, mem_next=0, resp_valid=0, resp_data=0, resp_err=0, buffer=0.

## Timing
- Request accepted at edge E (req_valid & req_ready).
- mem_req is high from cycle E+1.
- With mem_rvalid in the first BEAT0 cycle, resp_valid is high at E+2 for a non-crossing load, or E+3 for a crossing load.
- An error response is presented at E+1.
- Each memory wait cycle adds one cycle of latency.
- req_ready drops at E+1 and returns in the cycle after resp_valid & resp_ready. Back-to-back acceptance is therefore possible at that next edge.
- Reset mid-operation (BEAT0, BEAT1 or RESP): the next cycle is IDLE with all outputs at reset values; the pending response is discarded.
- No combinational path from any input to any output except req_ready, which depends on state only.

## Test plan
Fixtures, DATA_W=32, MISALIGN_EN=1: word A = 0x8899AABB, word B = 0x11223344.
- Byte loads, off=1, memory returns A:
  - signed → resp_data 0xFFFFFFAA;
  - unsigned → 0x000000AA;
  - resp_valid at E+2 with zero-wait memory.
- Crossing loads (A then B), two mem_req phases with mem_next 0 then 1:
  - half, off=3, signed → 0x00004488;
  - word, off=2 → 0x33448899.
- Errors, no mem_req ever asserted, each gives resp_err=1 and resp_data=0 at E+1:
  - size=3;
  - MISALIGN_EN=0 with half load at off=1.
- Backpressure: resp_ready held low 3 cycles → resp_valid, resp_data and resp_err stable; req_ready low; a second req_valid is not accepted until the cycle after the handshake.
- Memory waits: mem_rvalid delayed 4 cycles in BEAT0 → mem_req stays high and mem_next stays 0 throughout; the result is correct.
- Reset in BEAT1, followed by a late mem_rvalid → block in IDLE, mem_req=0, resp_valid=0, late data ignored; the next aligned word load at off=0 returns 0x8899AABB.

Source files
------------

// File: rtl/load_align_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit_if
// Brief    : Request, memory-read and response signals of load_align_unit.
// Revision : 1.0  initial release
// ============================================================================
interface load_align_unit_if #(
   parameter int DATA_W = 32
) ();
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   logic              req_valid;
   logic              req_ready;
   logic [OFF_W-1:0]  req_off;
   logic [1:0]        req_size;
   logic              req_signed;
   logic              mem_req;
   logic              mem_next;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;

   // slave: the load formatter; master: requester plus memory plus write-back
   modport slave (
      input  req_valid, req_off, req_size, req_signed, mem_rvalid, mem_rdata, resp_ready,
      output req_ready, mem_req, mem_next, resp_valid, resp_data, resp_err
   );
   modport master (
      output req_valid, req_off, req_size, req_signed, mem_rvalid, mem_rdata, resp_ready,
      input  req_ready, mem_req, mem_next, resp_valid, resp_data, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit
// Brief    : Aligns, assembles (1 or 2 beats) and extends memory loads.
// Revision : 1.0  initial release
// ============================================================================
module load_align_unit #(
   parameter int DATA_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  wire logic         clk,
   input  wire logic         reset,
   load_align_unit_if.slave  bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   logic [OFF_W:0]    w_len_q;
   logic              w_cross;
   logic              w_misalign_in;
   logic              w_err_in;
   logic [DATA_W-1:0] w_lo_nxt;
   logic [DATA_W-1:0] w_hi_nxt;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_fmt;

   assign w_len_q = (size_q == 2'd0) ? (OFF_W+1)'(NB) :
                    (size_q == 2'd1) ? (OFF_W+1)'(2)  : (OFF_W+1)'(1);
   assign w_cross = ({1'b0, off_q} + w_len_q) > (OFF_W+1)'(NB);

   assign w_misalign_in = ((bus.req_size == 2'd0) && (bus.req_off != '0)) ||
                          ((bus.req_size == 2'd1) && bus.req_off[0]);
   assign w_err_in      = (bus.req_size == 2'd3) || ((MISALIGN_EN == 0) && w_misalign_in);

   // The word arriving this cycle feeds the formatter directly so the result
   // is registered on the same edge that enters RESP.
   assign w_lo_nxt = ((state_q == BEAT0) && bus.mem_rvalid) ? bus.mem_rdata : lo_q;
   assign w_hi_nxt = ((state_q == BEAT1) && bus.mem_rvalid) ? bus.mem_rdata : hi_q;
   assign w_shift  = DATA_W'({w_hi_nxt, w_lo_nxt} >> {off_q, 3'b000});

   always_comb begin
      w_fmt = w_shift;
      case (size_q)
         2'd1:    w_fmt = {{(DATA_W-16){signed_q & w_shift[15]}}, w_shift[15:0]};
         2'd2:    w_fmt = {{(DATA_W-8){signed_q & w_shift[7]}}, w_shift[7:0]};
         default: w_fmt = w_shift;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      off_d    = off_q;
      size_d   = size_q;
      signed_d = signed_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      data_d   = data_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               off_d    = bus.req_off;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               if (w_err_in) begin
                  err_d   = 1'b1;
                  data_d  = '0;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = BEAT0;
               end
            end
         end
         BEAT0: begin
            if (bus.mem_rvalid) begin
               lo_d = bus.mem_rdata;
               if (w_cross) begin
                  state_d = BEAT1;
               end else begin
                  data_d  = w_fmt;
                  state_d = RESP;
               end
            end
         end
         BEAT1: begin
            if (bus.mem_rvalid) begin
               hi_d    = bus.mem_rdata;
               data_d  = w_fmt;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         off_q    <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.mem_req    = (state_q == BEAT0) || (state_q == BEAT1);
   assign bus.mem_next   = (state_q == BEAT1);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_data  = data_q;
   assign bus.resp_err   = err_q;
endmodule
`default_nettype wire
